// File: rtl/tm1638_display_arbiter_pkg.sv
// Shared types for the TM1638 display arbiter.
//   tm1638_types     : data words exchanged with tm1638_driver
//   tm1638_arb_types : arbiter FSM encoding and sizing constants

package tm1638_types;
    typedef logic [7:0] segments_t;
    typedef logic [7:0] leds_t;
endpackage

package tm1638_arb_types;
    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_PEND,
        ARB_SWITCH
    } arb_state_t;

    localparam int unsigned ARB_MAX_SRC = 16;
    localparam logic [15:0] ARB_CNT_MAX = 16'hFFFF;
endpackage

// File: rtl/tm1638_display_arbiter_next_idx.sv
// Combinational next-owner search: first enabled index after cur, wrapping
// NUM_SRC-1 -> 0. The search covers cur itself last, so a single enabled
// source re-selects itself. found=0 when the mask is all zero (nxt=cur).

module tm1638_arb_next_idx #(
    parameter int unsigned NUM_SRC = 8,
    localparam int unsigned SEL_W  = $clog2(NUM_SRC)
) (
    input  logic [SEL_W-1:0]   cur,
    input  logic [NUM_SRC-1:0] en,
    output logic [SEL_W-1:0]   nxt,
    output logic               found
);

    logic [SEL_W:0]   sum;
    logic [SEL_W:0]   wrap;
    logic [SEL_W-1:0] idx;

    // Scan cur+1 .. cur+NUM_SRC (mod NUM_SRC) and keep the first enabled hit
    always_comb begin
        nxt   = cur;
        found = 1'b0;
        sum   = '0;
        wrap  = '0;
        idx   = '0;
        for (int unsigned k = 1; k <= NUM_SRC; k++) begin
            sum  = {1'b0, cur} + (SEL_W+1)'(k);
            wrap = (sum >= (SEL_W+1)'(NUM_SRC)) ? sum - (SEL_W+1)'(NUM_SRC) : sum;
            idx  = wrap[SEL_W-1:0];
            if (!found && en[idx]) begin
                nxt   = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tm1638_display_arbiter.sv
// TM1638 display arbiter: shares one tm1638_driver between NUM_SRC producers.
// Only the current owner's updates are forwarded over a valid/ready
// handshake; ownership rotates on i_Next or, with i_Auto, a dwell timer.
// Optional build macro TM1638_ARB_DIAG_EN adds state/coalesce/switch
// diagnostic outputs.

module tm1638_display_arbiter
    import tm1638_types::*;
    import tm1638_arb_types::*;
#(
    parameter int unsigned NUM_SRC      = 8,
    parameter int unsigned DWELL_CYCLES = 5_400_000,
    localparam int unsigned SEL_W       = $clog2(NUM_SRC)
) (
    input  logic                        i_Clk,
    input  logic                        i_Rst_n,
    input  logic [NUM_SRC-1:0]          i_Src_En,
    input  logic [NUM_SRC-1:0]          i_Src_Valid,
    input  segments_t [NUM_SRC-1:0]     i_Src_Seg,
    input  leds_t [NUM_SRC-1:0]         i_Src_Leds,
    input  logic                        i_Next,
    input  logic                        i_Auto,
    input  logic                        i_Ready,
    output segments_t                   o_Segments,
    output leds_t                       o_Leds,
    output logic                        o_Valid,
    output logic [SEL_W-1:0]            o_Sel,
    output logic                        o_Switched
`ifdef TM1638_ARB_DIAG_EN
    ,
    output arb_state_t                  o_Diag_State,
    output logic [15:0]                 o_Diag_Coalesced,
    output logic [15:0]                 o_Diag_Switches
`endif
);

    localparam int unsigned     CNT_W      = $clog2(DWELL_CYCLES);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

    arb_state_t       state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    segments_t        seg_q, seg_d;
    leds_t            leds_q, leds_d;
    logic             switched_q, switched_d;
    logic             sw_pend_q, sw_pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [SEL_W-1:0] nxt_idx;
    logic             nxt_found;
    logic             owner_en;
    logic             owner_strobe;
    logic             any_en;
    logic             expire;
    logic             trig;

    tm1638_arb_next_idx #(
        .NUM_SRC(NUM_SRC)
    ) u_next_idx (
        .cur   (sel_q),
        .en    (i_Src_En),
        .nxt   (nxt_idx),
        .found (nxt_found)
    );

    assign owner_en     = i_Src_En[sel_q];
    assign owner_strobe = i_Src_Valid[sel_q] && owner_en;
    assign any_en       = |i_Src_En;
    assign expire       = i_Auto && (cnt_q == DWELL_LAST);
    assign trig         = i_Next || expire;

    // Register bank: FSM state, owner, data word, pulse, deferred switch, dwell counter
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q    <= ARB_IDLE;
            sel_q      <= '0;
            seg_q      <= '0;
            leds_q     <= '0;
            switched_q <= 1'b0;
            sw_pend_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            seg_q      <= seg_d;
            leds_q     <= leds_d;
            switched_q <= switched_d;
            sw_pend_q  <= sw_pend_d;
            cnt_q      <= cnt_d;
        end
    end

    // Next-state logic: capture/coalesce owner data, defer switches across a pending transfer
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        seg_d      = seg_q;
        leds_d     = leds_q;
        switched_d = 1'b0;
        sw_pend_d  = sw_pend_q;

        // Dwell counter restarts on every owner change and whenever rotation is off
        if (!i_Auto || state_q == ARB_SWITCH || expire) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            ARB_IDLE: begin
                if (owner_strobe) begin
                    seg_d   = i_Src_Seg[sel_q];
                    leds_d  = i_Src_Leds[sel_q];
                    state_d = ARB_PEND;
                    if (trig) begin
                        sw_pend_d = 1'b1;
                    end
                end else if ((trig || !owner_en) && any_en) begin
                    state_d = ARB_SWITCH;
                end
            end

            ARB_PEND: begin
                // A strobe on the transfer cycle reloads the register and keeps
                // o_Valid high; the deferred switch then waits for that word too.
                if (owner_strobe) begin
                    seg_d  = i_Src_Seg[sel_q];
                    leds_d = i_Src_Leds[sel_q];
                end
                if (trig) begin
                    sw_pend_d = 1'b1;
                end
                if (i_Ready && !owner_strobe) begin
                    sw_pend_d = 1'b0;
                    if ((sw_pend_q || trig) && any_en) begin
                        state_d = ARB_SWITCH;
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end
            end

            ARB_SWITCH: begin
                if (nxt_found) begin
                    sel_d      = nxt_idx;
                    seg_d      = i_Src_Seg[nxt_idx];
                    leds_d     = i_Src_Leds[nxt_idx];
                    switched_d = 1'b1;
                    state_d    = ARB_PEND;
                end else begin
                    state_d = ARB_IDLE;
                end
            end

            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    assign o_Segments = seg_q;
    assign o_Leds     = leds_q;
    assign o_Valid    = (state_q == ARB_PEND);
    assign o_Sel      = sel_q;
    assign o_Switched = switched_q;

`ifdef TM1638_ARB_DIAG_EN
    logic [15:0] coal_q;
    logic [15:0] swcnt_q;

    // Saturating counters: updates overwritten before transfer, and owner changes
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            coal_q  <= '0;
            swcnt_q <= '0;
        end else begin
            if (state_q == ARB_PEND && owner_strobe && !i_Ready && coal_q != ARB_CNT_MAX) begin
                coal_q <= coal_q + 16'd1;
            end
            if (state_q == ARB_SWITCH && nxt_found && swcnt_q != ARB_CNT_MAX) begin
                swcnt_q <= swcnt_q + 16'd1;
            end
        end
    end

    assign o_Diag_State     = state_q;
    assign o_Diag_Coalesced = coal_q;
    assign o_Diag_Switches  = swcnt_q;
`endif

endmodule

// File: tb/tb_tm1638_display_arbiter.sv
// Self-checking bench for tm1638_display_arbiter (NUM_SRC=8, DWELL_CYCLES=10).
// Source i drives seg 8'h40|i and leds 8'hC0|i, except source 0 whose
// segment value comes from the vector table.

module tb_tm1638_display_arbiter;
    import tm1638_types::*;
    import tm1638_arb_types::*;

    logic i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    logic             i_Rst_n;
    logic [7:0]       i_Src_En;
    logic [7:0]       i_Src_Valid;
    segments_t [7:0]  i_Src_Seg;
    leds_t [7:0]      i_Src_Leds;
    logic             i_Next;
    logic             i_Auto;
    logic             i_Ready;
    segments_t        o_Segments;
    leds_t            o_Leds;
    logic             o_Valid;
    logic [2:0]       o_Sel;
    logic             o_Switched;
`ifdef TM1638_ARB_DIAG_EN
    arb_state_t       o_Diag_State;
    logic [15:0]      o_Diag_Coalesced;
    logic [15:0]      o_Diag_Switches;
`endif

    tm1638_display_arbiter #(
        .NUM_SRC      (8),
        .DWELL_CYCLES (10)
    ) dut (
`ifdef TM1638_ARB_DIAG_EN
        .o_Diag_State     (o_Diag_State),
        .o_Diag_Coalesced (o_Diag_Coalesced),
        .o_Diag_Switches  (o_Diag_Switches),
`endif
        .i_Clk       (i_Clk),
        .i_Rst_n     (i_Rst_n),
        .i_Src_En    (i_Src_En),
        .i_Src_Valid (i_Src_Valid),
        .i_Src_Seg   (i_Src_Seg),
        .i_Src_Leds  (i_Src_Leds),
        .i_Next      (i_Next),
        .i_Auto      (i_Auto),
        .i_Ready     (i_Ready),
        .o_Segments  (o_Segments),
        .o_Leds      (o_Leds),
        .o_Valid     (o_Valid),
        .o_Sel       (o_Sel),
        .o_Switched  (o_Switched)
    );

    typedef struct packed {
        logic [7:0] en;
        logic [7:0] valid;
        logic [7:0] seg0;
        logic       nxt;
        logic       rdy;
        logic       exp_xfer;
        logic       exp_valid;
        logic [2:0] exp_sel;
        logic [7:0] exp_seg;
        logic       exp_sw;
    } vec_t;

    vec_t vecs [22];
    int   n_err = 0;
    int   n_chk = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_src(input logic [7:0] s0);
        for (int i = 0; i < 8; i++) begin
            i_Src_Seg[i]  = (i == 0) ? s0 : (8'h40 | 8'(i));
            i_Src_Leds[i] = 8'hC0 | 8'(i);
        end
    endtask

    task automatic cyc();
        @(posedge i_Clk);
        #1;
    endtask

    initial begin
        logic       act_xfer;
        logic [2:0] exp_sel;
        int         p;
        int         pulses;
        bit         seen;
        bit         any_v;
        bit         any_s;
        bit         bad_sel;

        //            en     valid  seg0   nx rd  xf vl sel   seg    sw
        vecs[0]  = '{8'hFF, 8'h01, 8'h3F, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 8'h3F, 1'b0};
        vecs[1]  = '{8'hFF, 8'h00, 8'h3F, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 8'h3F, 1'b0};
        vecs[2]  = '{8'hFF, 8'h01, 8'h06, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 8'h06, 1'b0};
        vecs[3]  = '{8'hFF, 8'h01, 8'h5B, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 8'h5B, 1'b0};
        vecs[4]  = '{8'hFF, 8'h00, 8'h5B, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 8'h5B, 1'b0};
        vecs[5]  = '{8'hFF, 8'h00, 8'h5B, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 8'h5B, 1'b0};
        vecs[6]  = '{8'h25, 8'h00, 8'h77, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'h5B, 1'b0};
        vecs[7]  = '{8'h25, 8'h00, 8'h77, 1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 8'h42, 1'b1};
        vecs[8]  = '{8'h25, 8'h00, 8'h77, 1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 8'h42, 1'b0};
        vecs[9]  = '{8'h25, 8'h00, 8'h77, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 8'h42, 1'b0};
        vecs[10] = '{8'h25, 8'h00, 8'h77, 1'b0, 1'b1, 1'b0, 1'b1, 3'd5, 8'h45, 1'b1};
        vecs[11] = '{8'h25, 8'h00, 8'h77, 1'b0, 1'b1, 1'b1, 1'b0, 3'd5, 8'h45, 1'b0};
        vecs[12] = '{8'h25, 8'h00, 8'h77, 1'b1, 1'b1, 1'b0, 1'b0, 3'd5, 8'h45, 1'b0};
        vecs[13] = '{8'h25, 8'h00, 8'h77, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 8'h77, 1'b1};
        vecs[14] = '{8'h25, 8'h00, 8'h77, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 8'h77, 1'b0};
        vecs[15] = '{8'h25, 8'h04, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h77, 1'b0};
        vecs[16] = '{8'h24, 8'h00, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h77, 1'b0};
        vecs[17] = '{8'h24, 8'h00, 8'h77, 1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 8'h42, 1'b1};
        vecs[18] = '{8'h24, 8'h00, 8'h77, 1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 8'h42, 1'b0};
        vecs[19] = '{8'h04, 8'h00, 8'h77, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 8'h42, 1'b0};
        vecs[20] = '{8'h04, 8'h00, 8'h77, 1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 8'h42, 1'b1};
        vecs[21] = '{8'h04, 8'h00, 8'h77, 1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 8'h42, 1'b0};

        // Reset state
        i_Rst_n = 1'b0;
        i_Src_En = '0;
        i_Src_Valid = '0;
        i_Next = 1'b0;
        i_Auto = 1'b0;
        i_Ready = 1'b0;
        set_src(8'h00);
        repeat (2) cyc();
        chk("rst_valid", 32'(o_Valid), 32'd0);
        chk("rst_sel", 32'(o_Sel), 32'd0);
        chk("rst_seg", 32'(o_Segments), 32'd0);
        chk("rst_leds", 32'(o_Leds), 32'd0);
        chk("rst_switched", 32'(o_Switched), 32'd0);
        i_Rst_n = 1'b1;
        cyc();

        // Capture, coalesce, manual switch with wrap, disabled owner, single source
        for (int i = 0; i < 22; i++) begin
            i_Src_En    = vecs[i].en;
            i_Src_Valid = vecs[i].valid;
            set_src(vecs[i].seg0);
            i_Next      = vecs[i].nxt;
            i_Ready     = vecs[i].rdy;
            act_xfer    = o_Valid && i_Ready;
            cyc();
            chk($sformatf("v%0d_xfer", i), 32'(act_xfer), 32'(vecs[i].exp_xfer));
            chk($sformatf("v%0d_valid", i), 32'(o_Valid), 32'(vecs[i].exp_valid));
            chk($sformatf("v%0d_sel", i), 32'(o_Sel), 32'(vecs[i].exp_sel));
            chk($sformatf("v%0d_seg", i), 32'(o_Segments), 32'(vecs[i].exp_seg));
            chk($sformatf("v%0d_leds", i), 32'(o_Leds), 32'(8'hC0 | 8'(vecs[i].exp_sel)));
            chk($sformatf("v%0d_switched", i), 32'(o_Switched), 32'(vecs[i].exp_sw));
        end
        i_Next = 1'b0;
        i_Src_Valid = '0;
`ifdef TM1638_ARB_DIAG_EN
        chk("diag_coalesced", 32'(o_Diag_Coalesced), 32'd1);
`endif

        // Switch request during a stalled transfer is deferred and applied once
        i_Src_En = 8'h25;
        i_Ready = 1'b0;
        i_Src_Valid = 8'h04;
        cyc();
        i_Src_Valid = '0;
        chk("defer_pend_valid", 32'(o_Valid), 32'd1);
        i_Next = 1'b1;
        cyc();
        chk("defer_sel_hold1", 32'(o_Sel), 32'd2);
        chk("defer_valid_hold", 32'(o_Valid), 32'd1);
        cyc();
        chk("defer_sel_hold2", 32'(o_Sel), 32'd2);
        i_Next = 1'b0;
        cyc();
        chk("defer_sel_hold3", 32'(o_Sel), 32'd2);
        chk("defer_no_switch", 32'(o_Switched), 32'd0);
        i_Ready = 1'b1;
        cyc();
        chk("defer_xfer_done", 32'(o_Valid), 32'd0);
        cyc();
        chk("defer_sel_adv", 32'(o_Sel), 32'd5);
        chk("defer_switched", 32'(o_Switched), 32'd1);
        chk("defer_refresh_seg", 32'(o_Segments), 32'h45);
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            cyc();
            if (o_Switched) pulses++;
        end
        chk("defer_single_adv_pulses", 32'(pulses), 32'd0);
        chk("defer_single_adv_sel", 32'(o_Sel), 32'd5);

        // Auto rotation on the dwell timer
        i_Src_En = 8'hFF;
        i_Auto = 1'b1;
        exp_sel = 3'd5;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            cyc();
            if (o_Switched) seen = 1'b1;
        end
        exp_sel = exp_sel + 3'd1;
        chk("auto_first_seen", 32'(seen), 32'd1);
        chk("auto_first_sel", 32'(o_Sel), 32'(exp_sel));
        seen = 1'b0;
        p = 0;
        for (int k = 0; k < 30 && !seen; k++) begin
            cyc();
            p++;
            if (o_Switched) seen = 1'b1;
        end
        exp_sel = exp_sel + 3'd1;
        chk("auto_second_seen", 32'(seen), 32'd1);
        chk("auto_period_10_to_12", 32'(p >= 10 && p <= 12), 32'd1);
        chk("auto_second_sel", 32'(o_Sel), 32'(exp_sel));

        // i_Next landing on the expiry cycle gives a single advance
        repeat (9) cyc();
        i_Next = 1'b1;
        cyc();
        i_Next = 1'b0;
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            cyc();
            if (o_Switched) pulses++;
        end
        exp_sel = exp_sel + 3'd1;
        chk("coincide_pulses", 32'(pulses), 32'd1);
        chk("coincide_sel", 32'(o_Sel), 32'(exp_sel));
        i_Auto = 1'b0;

        // Asynchronous reset in the middle of a pending transfer
        i_Next = 1'b1;
        cyc();
        i_Next = 1'b0;
        repeat (3) cyc();
        exp_sel = exp_sel + 3'd1;
        chk("prereset_sel", 32'(o_Sel), 32'(exp_sel));
        i_Ready = 1'b0;
        i_Src_Valid = 8'hFF;
        cyc();
        i_Src_Valid = '0;
        chk("prereset_valid", 32'(o_Valid), 32'd1);
        #3;
        i_Rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(o_Valid), 32'd0);
        chk("async_rst_sel", 32'(o_Sel), 32'd0);
        chk("async_rst_seg", 32'(o_Segments), 32'd0);
`ifdef TM1638_ARB_DIAG_EN
        chk("async_rst_diag_coal", 32'(o_Diag_Coalesced), 32'd0);
        chk("async_rst_diag_sw", 32'(o_Diag_Switches), 32'd0);
`endif
        cyc();
        i_Rst_n = 1'b1;

        // All-zero mask: no captures, no switches, owner holds
        i_Src_En = '0;
        i_Src_Valid = 8'hFF;
        i_Auto = 1'b1;
        i_Ready = 1'b1;
        any_v = 1'b0;
        any_s = 1'b0;
        bad_sel = 1'b0;
        for (int k = 0; k < 30; k++) begin
            i_Next = (k % 5 == 0);
            cyc();
            if (o_Valid) any_v = 1'b1;
            if (o_Switched) any_s = 1'b1;
            if (o_Sel != 3'd0) bad_sel = 1'b1;
        end
        chk("mask0_no_valid", 32'(any_v), 32'd0);
        chk("mask0_no_switch", 32'(any_s), 32'd0);
        chk("mask0_sel_held", 32'(bad_sel), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
